// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic congestion estimator.
// Holds the timebase constant, the congestion level encodings, the approach
// direction enum, the estimator FSM state type and the level classifier.
package traffic_pkg;

  localparam int unsigned ONE_SECOND = 50;

  localparam logic [1:0] LVL_FREE  = 2'd0;
  localparam logic [1:0] LVL_LIGHT = 2'd1;
  localparam logic [1:0] LVL_HEAVY = 2'd2;
  localparam logic [1:0] LVL_JAM   = 2'd3;

  // Same ordering as emergency_direction in the signal controller.
  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_S = 2'd1,
    DIR_E = 2'd2,
    DIR_W = 2'd3
  } direction_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } est_state_e;

  function automatic logic [1:0] classify_level(input logic [7:0] count,
                                                input logic [7:0] th_low,
                                                input logic [7:0] th_med,
                                                input logic [7:0] th_high);
    if (count < th_low)       return LVL_FREE;
    else if (count < th_med)  return LVL_LIGHT;
    else if (count < th_high) return LVL_HEAVY;
    else                      return LVL_JAM;
  endfunction

endpackage

// File: rtl/traffic_direction_counter.sv
// Per-approach tracker: live queue depth plus arrivals-per-window counter and
// the congestion level registered at each publish.
// Optional macro LEVEL_SMOOTH_EN: classify the average of the previous and the
// current window count instead of the current count alone.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   arrive, depart    one vehicle joined / left the approach this cycle
//   clear             hold the window counter (and smoothing history) at 0
//   publish           final window cycle: register level, restart the count
//   queue[7:0]        queue depth, saturating 0..255
//   window_count[7:0] arrivals so far in this window, saturating at 255
//   level[1:0]        last published congestion level
module traffic_direction_counter
  import traffic_pkg::*;
#(
  parameter int unsigned TH_LOW  = 5,
  parameter int unsigned TH_MED  = 10,
  parameter int unsigned TH_HIGH = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       arrive,
  input  logic       depart,
  input  logic       clear,
  input  logic       publish,
  output logic [7:0] queue,
  output logic [7:0] window_count,
  output logic [1:0] level
);

  logic [7:0] count_next;
  logic [7:0] classified;

  // Count including this cycle's pulse, so a final-cycle arrival is classified.
  always_comb begin
    count_next = window_count;
    if (arrive && (window_count != 8'hFF)) count_next = window_count + 8'd1;
  end

`ifdef LEVEL_SMOOTH_EN
  logic [7:0] prev_count;
  logic [8:0] smooth_sum;

  assign smooth_sum = {1'b0, prev_count} + {1'b0, count_next};
  assign classified = smooth_sum[8:1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     prev_count <= '0;
    else if (clear)   prev_count <= '0;
    else if (publish) prev_count <= count_next;
  end
`else
  assign classified = count_next;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      queue <= '0;
    end else begin
      unique case ({arrive, depart})
        2'b10:   if (queue != 8'hFF) queue <= queue + 8'd1;
        2'b01:   if (queue != 8'h00) queue <= queue - 8'd1;
        default: queue <= queue;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      window_count <= '0;
      level        <= LVL_FREE;
    end else if (clear) begin
      window_count <= '0;
    end else if (publish) begin
      window_count <= '0;
      level        <= classify_level(classified, 8'(TH_LOW), 8'(TH_MED), 8'(TH_HIGH));
    end else begin
      window_count <= count_next;
    end
  end

endmodule

// File: rtl/traffic_congestion_estimator.sv
// Traffic congestion estimator: tracks queue depth per approach, counts
// arrivals over fixed windows and publishes a 2-bit congestion level for each
// direction with a one-cycle valid strobe at every window boundary.
// Optional macro LEVEL_SMOOTH_EN (see traffic_direction_counter).
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   estimator_enable          1 = run windows, 0 = idle
//   <dir>_arrive/<dir>_depart detector pulses per approach
//   <dir>_ml_level[1:0]       registered congestion levels
//   ml_prediction_valid       one-cycle strobe after each publish edge
//   <dir>_queue[7:0]          registered queue depths
//   window_id[7:0]            publish count, wraps 255->0
module traffic_congestion_estimator
  import traffic_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 500,
  parameter int unsigned TH_LOW        = 5,
  parameter int unsigned TH_MED        = 10,
  parameter int unsigned TH_HIGH       = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       estimator_enable,
  input  logic       north_arrive,
  input  logic       south_arrive,
  input  logic       east_arrive,
  input  logic       west_arrive,
  input  logic       north_depart,
  input  logic       south_depart,
  input  logic       east_depart,
  input  logic       west_depart,
  output logic [1:0] north_ml_level,
  output logic [1:0] south_ml_level,
  output logic [1:0] east_ml_level,
  output logic [1:0] west_ml_level,
  output logic       ml_prediction_valid,
  output logic [7:0] north_queue,
  output logic [7:0] south_queue,
  output logic [7:0] east_queue,
  output logic [7:0] west_queue,
  output logic [7:0] window_id
);

  est_state_e  state;
  logic [15:0] window_cnt;
  logic        counting;
  logic        last_cycle;

  logic [3:0]  arrive_v;
  logic [3:0]  depart_v;
  logic [7:0]  queue_v  [4];
  logic [7:0]  count_v  [4];
  logic [1:0]  level_v  [4];

  assign arrive_v = {west_arrive, east_arrive, south_arrive, north_arrive};
  assign depart_v = {west_depart, east_depart, south_depart, north_depart};

  // An enable drop always wins over the final window cycle.
  assign counting   = (state == ST_COUNT) && estimator_enable;
  assign last_cycle = counting && (window_cnt == 16'(WINDOW_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= ST_IDLE;
      window_cnt          <= '0;
      window_id           <= '0;
      ml_prediction_valid <= 1'b0;
    end else begin
      ml_prediction_valid <= last_cycle;
      if (last_cycle) window_id <= window_id + 8'd1;
      unique case (state)
        ST_IDLE: begin
          window_cnt <= '0;
          if (estimator_enable) state <= ST_COUNT;
        end
        ST_COUNT: begin
          if (!estimator_enable) begin
            state      <= ST_IDLE;
            window_cnt <= '0;
          end else if (last_cycle) begin
            window_cnt <= '0;
          end else begin
            window_cnt <= window_cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar d = 0; d < 4; d++) begin : g_dir
    traffic_direction_counter #(
      .TH_LOW (TH_LOW),
      .TH_MED (TH_MED),
      .TH_HIGH(TH_HIGH)
    ) u_counter (
      .clk         (clk),
      .reset_n     (reset_n),
      .arrive      (arrive_v[d]),
      .depart      (depart_v[d]),
      .clear       (!counting),
      .publish     (last_cycle),
      .queue       (queue_v[d]),
      .window_count(count_v[d]),
      .level       (level_v[d])
    );
  end

  // Window counters are held clear whenever the estimator is idle.
  always_comb begin
    if (reset_n && (state == ST_IDLE))
      assert ((count_v[0] | count_v[1] | count_v[2] | count_v[3]) == 8'd0);
  end

  assign north_queue    = queue_v[DIR_N];
  assign south_queue    = queue_v[DIR_S];
  assign east_queue     = queue_v[DIR_E];
  assign west_queue     = queue_v[DIR_W];
  assign north_ml_level = level_v[DIR_N];
  assign south_ml_level = level_v[DIR_S];
  assign east_ml_level  = level_v[DIR_E];
  assign west_ml_level  = level_v[DIR_W];

endmodule

// File: tb/tb_traffic_congestion_estimator.sv
module tb_traffic_congestion_estimator;

  localparam int W       = 20;
  localparam int TH_LOW  = 5;
  localparam int TH_MED  = 10;
  localparam int TH_HIGH = 15;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] arr = '0;   // [0]=N [1]=S [2]=E [3]=W
  logic [3:0] dep = '0;

  logic [1:0] north_ml_level, south_ml_level, east_ml_level, west_ml_level;
  logic       ml_prediction_valid;
  logic [7:0] north_queue, south_queue, east_queue, west_queue, window_id;

  traffic_congestion_estimator #(
    .WINDOW_CYCLES(W),
    .TH_LOW       (TH_LOW),
    .TH_MED       (TH_MED),
    .TH_HIGH      (TH_HIGH)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .estimator_enable   (en),
    .north_arrive       (arr[0]),
    .south_arrive       (arr[1]),
    .east_arrive        (arr[2]),
    .west_arrive        (arr[3]),
    .north_depart       (dep[0]),
    .south_depart       (dep[1]),
    .east_depart        (dep[2]),
    .west_depart        (dep[3]),
    .north_ml_level     (north_ml_level),
    .south_ml_level     (south_ml_level),
    .east_ml_level      (east_ml_level),
    .west_ml_level      (west_ml_level),
    .ml_prediction_valid(ml_prediction_valid),
    .north_queue        (north_queue),
    .south_queue        (south_queue),
    .east_queue         (east_queue),
    .west_queue         (west_queue),
    .window_id          (window_id)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: a window is "running" with an elapsed-cycle index;
  // arrivals are tallied per direction and classified when it completes.
  int m_q[4], m_cnt[4], m_prev[4], m_lvl[4];
  int m_wc, m_id;
  bit m_run, m_valid;

  function automatic int classify(int c);
    if (c >= TH_HIGH) return 3;
    if (c >= TH_MED)  return 2;
    if (c >= TH_LOW)  return 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      m_q[d] = 0; m_cnt[d] = 0; m_prev[d] = 0; m_lvl[d] = 0;
    end
    m_wc = 0; m_id = 0; m_run = 0; m_valid = 0;
  endtask

  task automatic model_edge();
    for (int d = 0; d < 4; d++) begin
      if (arr[d] && !dep[d]) m_q[d] = (m_q[d] == 255) ? 255 : m_q[d] + 1;
      if (dep[d] && !arr[d]) m_q[d] = (m_q[d] == 0) ? 0 : m_q[d] - 1;
    end
    m_valid = 0;
    if (!m_run || !en) begin
      m_run = en && !m_run;
      m_wc = 0;
      for (int d = 0; d < 4; d++) begin m_cnt[d] = 0; m_prev[d] = 0; end
    end else begin
      for (int d = 0; d < 4; d++)
        if (arr[d]) m_cnt[d] = (m_cnt[d] == 255) ? 255 : m_cnt[d] + 1;
      if (m_wc == W - 1) begin
        for (int d = 0; d < 4; d++) begin
`ifdef LEVEL_SMOOTH_EN
          m_lvl[d] = classify((m_prev[d] + m_cnt[d]) / 2);
`else
          m_lvl[d] = classify(m_cnt[d]);
`endif
          m_prev[d] = m_cnt[d];
          m_cnt[d] = 0;
        end
        m_valid = 1;
        m_id = (m_id + 1) % 256;
        m_wc = 0;
      end else begin
        m_wc++;
      end
    end
  endtask

  function automatic logic [48:0] model_vec();
    return {2'(m_lvl[0]), 2'(m_lvl[1]), 2'(m_lvl[2]), 2'(m_lvl[3]), m_valid,
            8'(m_q[0]), 8'(m_q[1]), 8'(m_q[2]), 8'(m_q[3]), 8'(m_id)};
  endfunction

  function automatic logic [48:0] dut_vec();
    return {north_ml_level, south_ml_level, east_ml_level, west_ml_level,
            ml_prediction_valid, north_queue, south_queue, east_queue,
            west_queue, window_id};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Leaves the estimator so that the next edge processes window cycle 0.
  task automatic align();
    arr = '0; dep = '0; en = 1'b0;
    step();
    en = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b0; arr = '0; dep = '0;
    model_reset();
    step(); step();
    total_cnt++;
    if (dut_vec() !== 49'd0) $display("FAIL reset_state: got %h want 0", dut_vec());
    else pass_cnt++;
    reset_n = 1'b1;
  endtask

  task automatic test_idle_windows();
    int first_v = -1, second_v = -1;
    logic [7:0] id_at_first = '0;
    reset_n = 1'b0; en = 1'b1; arr = '0; dep = '0;
    #1; model_reset();
    reset_n = 1'b1;
    step();  // transition edge
    for (int i = 1; i <= 45; i++) begin
      step();
      if (ml_prediction_valid === 1'b1) begin
        if (first_v < 0) begin first_v = i; id_at_first = window_id; end
        else if (second_v < 0) second_v = i;
      end
      total_cnt++;
      if (dut_vec() !== model_vec())
        $display("FAIL idle_window c%0d: got %h want %h", i, dut_vec(), model_vec());
      else pass_cnt++;
    end
    total_cnt++;
    if (first_v != 20 || second_v != 40 || id_at_first !== 8'd1)
      $display("FAIL valid_timing: got %0d/%0d id %0d want 20/40 id 1", first_v, second_v, id_at_first);
    else pass_cnt++;
  endtask

  task automatic test_levels();
    logic [7:0] want;
`ifdef LEVEL_SMOOTH_EN
    want = {2'd1, 2'd0, 2'd1, 2'd0};
`else
    want = {2'd2, 2'd0, 2'd3, 2'd0};
`endif
    align();
    for (int i = 0; i < W; i++) begin
      arr = {1'b0, 1'(i < 15), 1'(i < 4), 1'(i < 12)};
      step();
      total_cnt++;
      if (dut_vec() !== model_vec())
        $display("FAIL levels c%0d: got %h want %h", i, dut_vec(), model_vec());
      else pass_cnt++;
    end
    total_cnt++;
    if ({north_ml_level, south_ml_level, east_ml_level, west_ml_level, ml_prediction_valid} !== {want, 1'b1})
      $display("FAIL levels_publish: got %b want %b",
               {north_ml_level, south_ml_level, east_ml_level, west_ml_level, ml_prediction_valid}, {want, 1'b1});
    else pass_cnt++;
    arr = '0;
    for (int i = 0; i < W - 1; i++) begin
      step();
      total_cnt++;
      if ({north_ml_level, south_ml_level, east_ml_level, west_ml_level, ml_prediction_valid} !== {want, 1'b0})
        $display("FAIL levels_hold c%0d: got %b want %b", i,
                 {north_ml_level, south_ml_level, east_ml_level, west_ml_level, ml_prediction_valid}, {want, 1'b0});
      else pass_cnt++;
    end
  endtask

  task automatic test_final_cycle_arrival();
    logic [1:0] want1, want2;
`ifdef LEVEL_SMOOTH_EN
    want1 = 2'd1; want2 = 2'd1;
`else
    want1 = 2'd3; want2 = 2'd0;
`endif
    align();
    for (int i = 0; i < W; i++) begin
      arr = {1'b0, 1'(i < 14 || i == W - 1), 2'b00};
      step();
    end
    total_cnt++;
    if (east_ml_level !== want1 || ml_prediction_valid !== 1'b1)
      $display("FAIL final_cycle_level: got %0d v%b want %0d v1", east_ml_level, ml_prediction_valid, want1);
    else pass_cnt++;
    for (int i = 0; i < W; i++) begin
      arr = {1'b0, 1'(i < 4), 2'b00};
      step();
    end
    total_cnt++;
    if (east_ml_level !== want2 || dut_vec() !== model_vec())
      $display("FAIL final_cycle_nocarry: got %0d want %0d", east_ml_level, want2);
    else pass_cnt++;
  endtask

  task automatic test_queue_saturation();
    en = 1'b0; arr = 4'b0001; dep = '0;
    for (int i = 0; i < 260; i++) begin
      step();
      total_cnt++;
      if (dut_vec() !== model_vec())
        $display("FAIL queue_up c%0d: got %h want %h", i, dut_vec(), model_vec());
      else pass_cnt++;
    end
    total_cnt++;
    if (north_queue !== 8'd255) $display("FAIL queue_sat: got %0d want 255", north_queue);
    else pass_cnt++;
    arr = '0; dep = 4'b0001;
    for (int i = 0; i < 260; i++) begin
      step();
      total_cnt++;
      if (dut_vec() !== model_vec())
        $display("FAIL queue_down c%0d: got %h want %h", i, dut_vec(), model_vec());
      else pass_cnt++;
    end
    total_cnt++;
    if (north_queue !== 8'd0) $display("FAIL queue_floor: got %0d want 0", north_queue);
    else pass_cnt++;
    arr = 4'b0001; dep = '0;
    step(); step(); step();
    arr = 4'b0001; dep = 4'b0001;
    for (int i = 0; i < 5; i++) step();
    total_cnt++;
    if (north_queue !== 8'd3) $display("FAIL queue_both: got %0d want 3", north_queue);
    else pass_cnt++;
    arr = '0; dep = '0;
  endtask

  task automatic test_enable_drop();
    logic [7:0] lv_before, id_before;
    align();
    lv_before = {north_ml_level, south_ml_level, east_ml_level, west_ml_level};
    id_before = window_id;
    for (int i = 0; i < 10; i++) begin
      arr = {3'b000, 1'(i < 8)};
      step();
    end
    arr = '0; en = 1'b0;
    step();
    total_cnt++;
    if (ml_prediction_valid !== 1'b0 || window_id !== id_before ||
        {north_ml_level, south_ml_level, east_ml_level, west_ml_level} !== lv_before)
      $display("FAIL drop_mid: got v%b id %0d lv %h want v0 id %0d lv %h", ml_prediction_valid,
               window_id, {north_ml_level, south_ml_level, east_ml_level, west_ml_level}, id_before, lv_before);
    else pass_cnt++;
    en = 1'b1;
    step();
    for (int i = 0; i < W; i++) begin
      arr = {3'b000, 1'(i < 3)};
      step();
      total_cnt++;
      if (dut_vec() !== model_vec())
        $display("FAIL drop_rerun c%0d: got %h want %h", i, dut_vec(), model_vec());
      else pass_cnt++;
    end
    total_cnt++;
    if (north_ml_level !== 2'd0 || ml_prediction_valid !== 1'b1)
      $display("FAIL drop_fresh_count: got %0d v%b want 0 v1", north_ml_level, ml_prediction_valid);
    else pass_cnt++;
    align();
    id_before = window_id;
    arr = 4'b1111;
    for (int i = 0; i < W - 1; i++) step();
    en = 1'b0;
    step();
    arr = '0;
    total_cnt++;
    if (ml_prediction_valid !== 1'b0 || window_id !== id_before || dut_vec() !== model_vec())
      $display("FAIL drop_final: got v%b id %0d want v0 id %0d", ml_prediction_valid, window_id, id_before);
    else pass_cnt++;
  endtask

  task automatic test_reset_midwindow();
    align();
    for (int i = 0; i < 7; i++) begin
      arr = 4'($urandom_range(0, 15));
      step();
    end
    arr = '0;
    reset_n = 1'b0;
    #1;
    model_reset();
    total_cnt++;
    if (dut_vec() !== 49'd0) $display("FAIL reset_async: got %h want 0", dut_vec());
    else pass_cnt++;
    #1 reset_n = 1'b1;
  endtask

  task automatic test_smooth();
    logic [1:0] want1, want2;
`ifdef LEVEL_SMOOTH_EN
    want1 = 2'd2; want2 = 2'd2;
`else
    want1 = 2'd3; want2 = 2'd0;
`endif
    align();
    arr = 4'b0001;
    for (int i = 0; i < W; i++) step();
    total_cnt++;
    if (north_ml_level !== want1) $display("FAIL smooth_first: got %0d want %0d", north_ml_level, want1);
    else pass_cnt++;
    arr = '0;
    for (int i = 0; i < W; i++) step();
    total_cnt++;
    if (north_ml_level !== want2 || ml_prediction_valid !== 1'b1)
      $display("FAIL smooth_second: got %0d v%b want %0d v1", north_ml_level, ml_prediction_valid, want2);
    else pass_cnt++;
  endtask

  task automatic test_random();
    bit prev_valid = 0;
    for (int i = 0; i < 900; i++) begin
      en  = ($urandom_range(0, 99) < 97);
      for (int d = 0; d < 4; d++) begin
        arr[d] = ($urandom_range(0, 99) < 45);
        dep[d] = ($urandom_range(0, 99) < 35);
      end
      step();
      total_cnt++;
      if (dut_vec() !== model_vec() || (prev_valid && ml_prediction_valid))
        $display("FAIL random c%0d: got %h want %h", i, dut_vec(), model_vec());
      else pass_cnt++;
      prev_valid = ml_prediction_valid;
    end
    arr = '0; dep = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle_windows();
    test_levels();
    test_final_cycle_arrival();
    test_queue_saturation();
    test_enable_drop();
    test_reset_midwindow();
    test_smooth();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
